cam_capture: RTL and testbench

- Writer side of the live-feed frame buffer.
- Samples an OV7670-style camera port (PCLK, VSYNC, HREF, 8-bit data carrying RGB565 as two bytes per pixel).
- Converts each pixel to 12-bit RGB444 and issues one write per pixel into the live-feed block memory.
- The display path reads that same memory and presents it as op_pixel {R[11:8], G[7:4], B[3:0]}.
- Runs entirely on the system clock; the camera signals are treated as asynchronous inputs and oversampled.

---
 rtl/cam_capture_pkg.sv | 32 +++
 rtl/cam_capture_edge_sync.sv | 31 +++
 rtl/cam_capture.sv | 170 +++++++++++++++++
 tb/tb_cam_capture.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture path: FSM states, frame geometry
// defaults, and the RGB444 field layout also used by the display-side op_pixel.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FRAME
  } state_e;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  // hi/lo are the two camera bytes of one RGB565 pixel, in arrival order.
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    logic [11:0] px;
    px                = '0;
    px[R_MSB:R_LSB]   = hi[7:4];
    px[G_MSB:G_LSB]   = {hi[2:0], lo[7]};
    px[B_MSB:B_LSB]   = lo[4:1];
    return px;
  endfunction

endpackage

// File: rtl/cam_capture_edge_sync.sv
// Two-flop synchroniser for an asynchronous camera control line, plus a third flop
// so the synchronised level can be edge-detected.
module cam_capture_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  // NOTE: non-blocking assignments keep the three stages a true shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/cam_capture.sv
// Writer side of the live-feed frame buffer: oversamples an OV7670-style port, packs
// RGB565 byte pairs into RGB444 and issues one memory write per in-bounds pixel.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_PX = H_ACTIVE * V_ACTIVE;
  localparam int COL_W    = $clog2(H_ACTIVE + 1);
  localparam int LINE_W   = $clog2(V_ACTIVE + 1);
  localparam int PIX_W    = $clog2(FRAME_PX + 1) + 1;

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE);
  localparam logic [PIX_W-1:0]  PIX_GOAL = PIX_W'(FRAME_PX);

  logic pclk_rise, vsync_rise, vsync_fall, href_s2, href_fall;
  logic pclk_s2, pclk_fall, vsync_s2, href_rise;
  logic unused_edges;
  logic [7:0] data_s1_q, data_s2_q;

  cam_capture_edge_sync u_pclk_sync (
    .clock(clock), .reset(reset), .din(cam_pclk),
    .sync(pclk_s2), .rise(pclk_rise), .fall(pclk_fall)
  );
  cam_capture_edge_sync u_vsync_sync (
    .clock(clock), .reset(reset), .din(cam_vsync),
    .sync(vsync_s2), .rise(vsync_rise), .fall(vsync_fall)
  );
  cam_capture_edge_sync u_href_sync (
    .clock(clock), .reset(reset), .din(cam_href),
    .sync(href_s2), .rise(href_rise), .fall(href_fall)
  );

  assign unused_edges = ^{pclk_s2, pclk_fall, vsync_s2, href_rise};

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    base_d       = base_q;
    pix_d        = pix_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (capture_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (vsync_fall) begin
          col_d   = '0;
          line_d  = '0;
          base_d  = '0;
          pix_d   = '0;
          phase_d = 1'b0;
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        // vsync wins over a coincident byte strobe; that byte is dropped.
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          frame_err_d  = (pix_q != PIX_GOAL);
          state_d      = capture_en ? S_WAIT : S_IDLE;
        end else if (href_fall) begin
          if (col_q != '0 && line_q != LINE_MAX) begin
            line_d = line_q + 1'b1;
            base_d = base_q + ADDR_W'(H_ACTIVE);
          end
          col_d   = '0;
          phase_d = 1'b0;
        end else if (pclk_rise && href_s2) begin
          if (!phase_q) begin
            hi_d    = data_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pix_q != '1) pix_d = pix_q + 1'b1;
            if (col_q < COL_MAX && line_q < LINE_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_q + ADDR_W'(col_q);
              wr_data_d = rgb565_to_444(hi_q, data_s2_q);
            end
            if (col_q < COL_MAX) col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      state_q      <= S_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      base_q       <= '0;
      pix_q        <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_s1_q    <= cam_data;
      data_s2_q    <= data_s1_q;
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      base_q       <= base_d;
      pix_q        <= pix_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a reduced 20x8 frame: stimulus tasks drive the
// camera port and update a pixel-level reference model; a monitor checks every write.
module tb_cam_capture;

  localparam int H  = 20;
  localparam int V  = 8;
  localparam int AW = 8;
  localparam int FP = H * V;

  logic          clock = 1'b0;
  logic          reset;
  logic          capture_en;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  always #5 clock = ~clock;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef enum { M_IDLE, M_WAIT, M_FRAME } mstate_e;

  wr_t     exp_wr[$];
  bit      exp_err[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      n_writes = 0;
  int      n_done   = 0;
  int      last_addr = -1;
  int      last_data = -1;

  // Reference model: frame position in pixels, filled from the byte stream.
  mstate_e m_state = M_IDLE;
  int      m_col, m_line, m_pix, m_hi;
  bit      m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int px444(input int hi, input int lo);
    int r, g, b;
    r = (hi >> 4) & 15;
    g = ((hi & 7) << 1) | ((lo >> 7) & 1);
    b = (lo >> 1) & 15;
    return (r << 8) | (g << 4) | b;
  endfunction

  // Monitor: compare every write and every frame_done against the queued expectations.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (wr_en === 1'b1) begin
        n_writes++;
        last_addr = int'(wr_addr);
        last_data = int'(wr_data);
        check("wr_addr_in_range", 32'(wr_addr < FP), 32'd1);
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), e.addr);
          check("wr_data", 32'(wr_data), e.data);
        end
      end
      if (frame_done === 1'b1) begin
        n_done++;
        if (exp_err.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_done: frame_err %0b, no pulse expected", frame_err);
        end else begin
          check("frame_err", 32'(frame_err), 32'(exp_err.pop_front()));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (m_state == M_FRAME && cam_href) begin
      if (!m_phase) begin
        m_hi    = b;
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
        m_pix++;
        if (m_col < H && m_line < V) exp_wr.push_back('{addr: m_line * H + m_col, data: px444(m_hi, b)});
        if (m_col < H) m_col++;
      end
    end
    cam_data = b;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic end_line();
    cam_pclk = 1'b0;
    tick(2);
    cam_href = 1'b0;
    if (m_state == M_FRAME) begin
      if (m_col > 0 && m_line < V) m_line++;
      m_col   = 0;
      m_phase = 1'b0;
    end
    tick(6);
  endtask

  task automatic send_line(input int npix, input bit by_col, input bit extra);
    logic [15:0] w;
    cam_href = 1'b1;
    tick(3);
    for (int c = 0; c < npix; c++) begin
      w = by_col ? 16'(c) : 16'($urandom);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    if (extra) send_byte(8'($urandom));
    end_line();
  endtask

  task automatic set_en(input bit en);
    capture_en = en;
    tick(3);
    if (en && m_state == M_IDLE) m_state = M_WAIT;
  endtask

  task automatic frame_start();
    cam_vsync = 1'b0;
    if (m_state == M_WAIT) begin
      m_state = M_FRAME;
      m_col   = 0;
      m_line  = 0;
      m_pix   = 0;
      m_phase = 1'b0;
    end
    tick(6);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    if (m_state == M_FRAME) begin
      exp_err.push_back(m_pix != FP);
      m_state = capture_en ? M_WAIT : M_IDLE;
    end
    tick(6);
  endtask

  initial begin
    int w0, d0;
    reset      = 1'b1;
    capture_en = 1'b0;
    cam_pclk   = 1'b0;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);

    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_frame_err", 32'(frame_err), 0);

    // Single pixel line: F8 1F -> F0F at address 0.
    set_en(1'b1);
    check("busy_armed", 32'(busy), 1);
    frame_start();
    w0 = n_writes;
    cam_href = 1'b1;
    tick(3);
    send_byte(8'hF8);
    send_byte(8'h1F);
    end_line();
    frame_end();
    check("single_px_writes", n_writes - w0, 1);
    check("single_px_addr", last_addr, 0);
    check("single_px_data", last_data, 32'hF0F);

    // Full frame, pixel value = column.
    frame_start();
    w0 = n_writes;
    d0 = n_done;
    for (int l = 0; l < V; l++) send_line(H, 1'b1, 1'b0);
    frame_end();
    check("full_writes", n_writes - w0, FP);
    check("full_last_addr", last_addr, FP - 1);
    check("full_done_pulses", n_done - d0, 1);

    // Overlong lines and frame.
    frame_start();
    w0 = n_writes;
    for (int l = 0; l < V + 2; l++) send_line(H + 2, 1'b0, 1'b0);
    frame_end();
    check("overlong_writes", n_writes - w0, FP);

    // Odd byte at line end: only one write, next line starts clean at col 0.
    frame_start();
    w0 = n_writes;
    send_line(1, 1'b0, 1'b1);
    send_line(2, 1'b0, 1'b0);
    frame_end();
    check("odd_byte_writes", n_writes - w0, 3);
    check("odd_byte_next_line_addr", last_addr, H + 1);

    // Randomised frames: ragged line lengths, dangling bytes, empty lines.
    for (int f = 0; f < 2; f++) begin
      frame_start();
      for (int l = 0; l < V - 1 + int'($urandom_range(0, 2)); l++)
        send_line($urandom_range(0, H + 2), 1'b0, 1'($urandom_range(0, 1)));
      frame_end();
    end

    // capture_en dropped mid-frame: frame completes, then the FSM idles.
    frame_start();
    d0 = n_done;
    send_line(H, 1'b0, 1'b0);
    capture_en = 1'b0;
    for (int l = 1; l < V; l++) send_line(H, 1'b0, 1'b0);
    frame_end();
    tick(2);
    check("disarm_done_pulses", n_done - d0, 1);
    check("disarm_busy", 32'(busy), 0);
    w0 = n_writes;
    frame_start();
    send_line(H, 1'b0, 1'b0);
    frame_end();
    check("disarm_no_writes", n_writes - w0, 0);

    // Async reset mid-line: everything clears at once, no frame_done.
    set_en(1'b1);
    frame_start();
    d0 = n_done;
    send_line(H, 1'b0, 1'b0);
    cam_href = 1'b1;
    tick(3);
    for (int c = 0; c < 3; c++) begin
      send_byte(8'($urandom));
      send_byte(8'($urandom));
    end
    tick(8);
    check("pre_reset_drained", exp_wr.size(), 0);
    capture_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_wr_en", 32'(wr_en), 0);
    check("async_reset_wr_addr", 32'(wr_addr), 0);
    check("async_reset_busy", 32'(busy), 0);
    m_state = M_IDLE;
    tick(2);
    reset = 1'b0;
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(4);
    w0 = n_writes;
    frame_end();
    frame_start();
    send_line(H, 1'b0, 1'b0);
    frame_end();
    check("post_reset_ignored_writes", n_writes - w0, 0);
    check("post_reset_no_done", n_done - d0, 0);
    set_en(1'b1);
    frame_start();
    w0 = n_writes;
    send_line(H, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    frame_end();
    check("rearmed_writes", n_writes - w0, 2 * H);

    tick(10);
    check("exp_writes_left", exp_wr.size(), 0);
    check("exp_done_left", exp_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
